// File: rtl/scarv_axi_lite_arb2_if.sv
// AXI4-lite bus bundle used on both sides of the two-master arbiter.
// The "master" modport is the side that issues requests; "slave" answers them.
interface scarv_axi_lite_arb2_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/scarv_axi_lite_arb2.sv
// Two-master / one-slave AXI4-lite arbiter (PicoRV32 on m0, XCrypto COP on m1).
// Read and write paths have independent FSMs, each with a registered grant and
// a single outstanding transaction. Ties go round-robin or to m0 (RR_EN).
module scarv_axi_lite_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic                        g_clk,
  input  logic                        g_resetn,
  scarv_axi_lite_arb2_if.slave        m0,
  scarv_axi_lite_arb2_if.slave        m1,
  scarv_axi_lite_arb2_if.master       s
);

  localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_RESP = 2'd2;

  logic [1:0] wstate, rstate;
  logic       wgnt, rgnt, last_w, last_r, aw_done, w_done;

  // Grant choice: single requester wins; a tie goes to the previous loser
  // (round-robin) or always to m0.
  function automatic logic pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return RR_EN ? ~last : 1'b0;
    return req1;
  endfunction

  logic wreq0, wreq1, rreq0, rreq1;
  assign wreq0 = m0.awvalid | m0.wvalid;
  assign wreq1 = m1.awvalid | m1.wvalid;
  assign rreq0 = m0.arvalid;
  assign rreq1 = m1.arvalid;

  logic w_addr, w_resp, w_act, r_addr, r_resp, r_act;
  assign w_addr = (wstate == W_ADDR);
  assign w_resp = (wstate == W_RESP);
  assign w_act  = w_addr | w_resp;
  assign r_addr = (rstate == R_ADDR);
  assign r_resp = (rstate == R_RESP);
  assign r_act  = r_addr | r_resp;

  // Granted-master views of the request side.
  logic        g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic [31:0] g_awaddr, g_wdata, g_araddr;
  logic [2:0]  g_awprot, g_arprot;
  logic [3:0]  g_wstrb;
  assign g_awvalid = wgnt ? m1.awvalid : m0.awvalid;
  assign g_awaddr  = wgnt ? m1.awaddr  : m0.awaddr;
  assign g_awprot  = wgnt ? m1.awprot  : m0.awprot;
  assign g_wvalid  = wgnt ? m1.wvalid  : m0.wvalid;
  assign g_wdata   = wgnt ? m1.wdata   : m0.wdata;
  assign g_wstrb   = wgnt ? m1.wstrb   : m0.wstrb;
  assign g_bready  = wgnt ? m1.bready  : m0.bready;
  assign g_arvalid = rgnt ? m1.arvalid : m0.arvalid;
  assign g_araddr  = rgnt ? m1.araddr  : m0.araddr;
  assign g_arprot  = rgnt ? m1.arprot  : m0.arprot;
  assign g_rready  = rgnt ? m1.rready  : m0.rready;

  // Slave-side valids come only from registered state and master valids,
  // never from a slave ready.
  logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  assign s_awvalid = w_addr & g_awvalid & ~aw_done;
  assign s_wvalid  = w_addr & g_wvalid & ~w_done;
  assign s_bready  = w_resp & g_bready;
  assign s_arvalid = r_addr & g_arvalid;
  assign s_rready  = r_resp & g_rready;

  assign s.awvalid = s_awvalid;
  assign s.wvalid  = s_wvalid;
  assign s.bready  = s_bready;
  assign s.arvalid = s_arvalid;
  assign s.rready  = s_rready;
  assign s.awaddr  = w_act ? g_awaddr : 32'd0;
  assign s.awprot  = w_act ? g_awprot : 3'd0;
  assign s.wdata   = w_act ? g_wdata  : 32'd0;
  assign s.wstrb   = w_act ? g_wstrb  : 4'd0;
  assign s.araddr  = r_act ? g_araddr : 32'd0;
  assign s.arprot  = r_act ? g_arprot : 3'd0;

  // Responses reach a master only in the RESP state, so an early slave
  // response is held off rather than routed or dropped.
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  assign aw_ready = w_addr & s.awready & ~aw_done;
  assign w_ready  = w_addr & s.wready & ~w_done;
  assign b_valid  = w_resp & s.bvalid;
  assign ar_ready = r_addr & s.arready;
  assign r_valid  = r_resp & s.rvalid;

  assign m0.awready = aw_ready & ~wgnt;
  assign m1.awready = aw_ready &  wgnt;
  assign m0.wready  = w_ready  & ~wgnt;
  assign m1.wready  = w_ready  &  wgnt;
  assign m0.bvalid  = b_valid  & ~wgnt;
  assign m1.bvalid  = b_valid  &  wgnt;
  assign m0.arready = ar_ready & ~rgnt;
  assign m1.arready = ar_ready &  rgnt;
  assign m0.rvalid  = r_valid  & ~rgnt;
  assign m1.rvalid  = r_valid  &  rgnt;
  assign m0.rdata   = (r_resp & ~rgnt) ? s.rdata : 32'd0;
  assign m1.rdata   = (r_resp &  rgnt) ? s.rdata : 32'd0;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = s_awvalid & s.awready;
  assign w_hs  = s_wvalid & s.wready;
  assign b_hs  = b_valid & g_bready;
  assign ar_hs = s_arvalid & s.arready;
  assign r_hs  = r_valid & g_rready;

  // Write path: grant, collect AW and W handshakes in any order, then wait for B.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wstate  <= W_IDLE;
      wgnt    <= 1'b0;
      last_w  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (wreq0 | wreq1) begin
          wgnt   <= pick(wreq0, wreq1, last_w);
          wstate <= W_ADDR;
        end
        W_ADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) & (w_done | w_hs)) wstate <= W_RESP;
        end
        W_RESP: if (b_hs) begin
          wstate  <= W_IDLE;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          last_w  <= wgnt;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read path: grant, forward AR, then forward R until its handshake.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rstate <= R_IDLE;
      rgnt   <= 1'b0;
      last_r <= 1'b1;
    end else begin
      case (rstate)
        R_IDLE: if (rreq0 | rreq1) begin
          rgnt   <= pick(rreq0, rreq1, last_r);
          rstate <= R_ADDR;
        end
        R_ADDR: if (ar_hs) rstate <= R_RESP;
        R_RESP: if (r_hs) begin
          rstate <= R_IDLE;
          last_r <= rgnt;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
